cache_control_nway: RTL and testbench

CACHE_CONTROL_NWAY -- requirements
Module: cache_control_nway

---
 rtl/cache_control_nway.sv | 165 ++++++++++++++++
 tb/tb_cache_control_nway.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control_nway.sv
// N-way cache controller: hit/miss decision, dirty writeback, line fill and
// performance counters.
module cache_control_nway #(
   parameter int  WAYS  = 4,
   parameter int  CNT_W = 16,
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             pmem_resp,
   input  logic [WAYS-1:0]  hit,
   input  logic [WAYS-1:0]  valid,
   input  logic [WAYS-1:0]  dirty,
   input  logic [WAY_W-1:0] victim,
   input  logic             cnt_clr,
   output logic             mem_resp,
   output logic             pmem_read,
   output logic             pmem_write,
   output logic             lru_load,
   output logic [WAY_W-1:0] way_sel,
   output logic [WAYS-1:0]  data_load,
   output logic [WAYS-1:0]  tag_load,
   output logic [WAYS-1:0]  valid_load,
   output logic [WAYS-1:0]  dirty_load,
   output logic             dirty_in,
   output logic             data_src,
   output logic             pmem_addr_sel,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt,
   output logic [CNT_W-1:0] wb_cnt
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHECK     = 3'd1,
      WRITEBACK = 3'd2,
      FILL      = 3'd3,
      RESP_WAIT = 3'd4
   } state_t;

   state_t           state;
   logic [WAY_W-1:0] vway;
   logic             refill;

   logic             any_hit;
   logic             wr_op;
   logic             victim_dirty;
   logic [WAY_W-1:0] hw;

   function automatic logic [WAY_W-1:0] lowest_way(input logic [WAYS-1:0] v);
      lowest_way = '0;
      for (int i = WAYS - 1; i >= 0; i--)
         if (v[i]) lowest_way = WAY_W'(i);
   endfunction

   function automatic logic [WAYS-1:0] onehot(input logic [WAY_W-1:0] w);
      onehot    = '0;
      onehot[w] = 1'b1;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      sat_inc = (&c) ? c : c + CNT_W'(1);
   endfunction

   // A simultaneous read and write is treated as a read.
   assign any_hit      = |hit;
   assign hw           = lowest_way(hit);
   assign wr_op        = mem_write & ~mem_read;
   assign victim_dirty = valid[victim] & dirty[victim];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         vway     <= '0;
         refill   <= 1'b0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
         wb_cnt   <= '0;
      end else begin
         case (state)
            IDLE:
               if (mem_read || mem_write) state <= CHECK;
            CHECK: begin
               refill <= 1'b0;
               if (any_hit) begin
                  state <= IDLE;
               end else begin
                  vway  <= victim;
                  state <= victim_dirty ? WRITEBACK : FILL;
               end
            end
            WRITEBACK:
               if (pmem_resp) state <= FILL;
            FILL:
               if (pmem_resp) state <= RESP_WAIT;
            RESP_WAIT: begin
               // The re-check after a fill is not a genuine hit.
               refill <= 1'b1;
               state  <= CHECK;
            end
            default:
               state <= IDLE;
         endcase

         if (cnt_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
         end else begin
            if (state == CHECK && any_hit && !refill) hit_cnt <= sat_inc(hit_cnt);
            if (state == CHECK && !any_hit) miss_cnt <= sat_inc(miss_cnt);
            if (state == WRITEBACK && pmem_resp) wb_cnt <= sat_inc(wb_cnt);
         end
      end
   end

   always_comb begin
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      lru_load      = 1'b0;
      way_sel       = '0;
      data_load     = '0;
      tag_load      = '0;
      valid_load    = '0;
      dirty_load    = '0;
      dirty_in      = 1'b0;
      data_src      = 1'b0;
      pmem_addr_sel = 1'b0;
      case (state)
         CHECK:
            if (any_hit) begin
               way_sel  = hw;
               lru_load = 1'b1;
               mem_resp = 1'b1;
               if (wr_op) begin
                  data_load  = onehot(hw);
                  dirty_load = onehot(hw);
                  dirty_in   = 1'b1;
               end
            end
         WRITEBACK: begin
            pmem_write    = 1'b1;
            pmem_addr_sel = 1'b1;
            way_sel       = vway;
            if (pmem_resp) dirty_load = onehot(vway);
         end
         FILL: begin
            pmem_read = 1'b1;
            way_sel   = vway;
            if (pmem_resp) begin
               data_load  = onehot(vway);
               tag_load   = onehot(vway);
               valid_load = onehot(vway);
               dirty_load = onehot(vway);
               data_src   = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_control_nway.sv
// Scoreboard bench for cache_control_nway: directed hit, miss, counter, reset
// and associativity scenarios.
module tb_cache_control_nway;

   typedef struct packed {
      logic [1:0] way_sel;
      logic       lru_load;
      logic [3:0] data_load;
      logic [3:0] tag_load;
      logic [3:0] valid_load;
      logic [3:0] dirty_load;
      logic       dirty_in;
      logic       data_src;
      logic [1:0] pmem_rw;
      logic       addr_sel;
   } resp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int pmem_lat = 2;
   int pmem_cnt = 0;
   resp_t exp_q[$];
   resp_t mon_exp, mon_got;

   // Main instance (WAYS=4, CNT_W=16)
   logic        m_read = 0, m_write = 0, m_clr = 0, pmem_resp = 0;
   logic [3:0]  m_hit = 0, m_valid = 0, m_dirty = 0;
   logic [1:0]  m_victim = 0;
   logic        m_mem_resp, m_pmem_read, m_pmem_write, m_lru_load;
   logic [1:0]  m_way_sel;
   logic [3:0]  m_data_load, m_tag_load, m_valid_load, m_dirty_load;
   logic        m_dirty_in, m_data_src, m_addr_sel;
   logic [15:0] m_hit_cnt, m_miss_cnt, m_wb_cnt;

   cache_control_nway #(.WAYS(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .mem_read(m_read), .mem_write(m_write),
      .pmem_resp(pmem_resp), .hit(m_hit), .valid(m_valid), .dirty(m_dirty),
      .victim(m_victim), .cnt_clr(m_clr), .mem_resp(m_mem_resp),
      .pmem_read(m_pmem_read), .pmem_write(m_pmem_write), .lru_load(m_lru_load),
      .way_sel(m_way_sel), .data_load(m_data_load), .tag_load(m_tag_load),
      .valid_load(m_valid_load), .dirty_load(m_dirty_load), .dirty_in(m_dirty_in),
      .data_src(m_data_src), .pmem_addr_sel(m_addr_sel), .hit_cnt(m_hit_cnt),
      .miss_cnt(m_miss_cnt), .wb_cnt(m_wb_cnt));

   // Sweep instances share request strobes
   logic        a_read = 0, a_clr = 0;
   logic [7:0]  a_hit8 = 0;
   logic [1:0]  a_hit2 = 0;

   logic        c2_resp, c2_pr, c2_pw, c2_lru, c2_di, c2_ds, c2_as;
   logic [1:0]  c2_way;
   logic [3:0]  c2_dl, c2_tl, c2_vl, c2_yl;
   logic [1:0]  c2_hc, c2_mc, c2_wc;
   cache_control_nway #(.WAYS(4), .CNT_W(2)) u_c2 (
      .clk(clk), .rst(rst), .mem_read(a_read), .mem_write(1'b0), .pmem_resp(1'b0),
      .hit(a_hit8[3:0]), .valid(4'b0), .dirty(4'b0), .victim(2'b0), .cnt_clr(a_clr),
      .mem_resp(c2_resp), .pmem_read(c2_pr), .pmem_write(c2_pw), .lru_load(c2_lru),
      .way_sel(c2_way), .data_load(c2_dl), .tag_load(c2_tl), .valid_load(c2_vl),
      .dirty_load(c2_yl), .dirty_in(c2_di), .data_src(c2_ds), .pmem_addr_sel(c2_as),
      .hit_cnt(c2_hc), .miss_cnt(c2_mc), .wb_cnt(c2_wc));

   logic        w8_resp, w8_pr, w8_pw, w8_lru, w8_di, w8_ds, w8_as;
   logic [2:0]  w8_way;
   logic [7:0]  w8_dl, w8_tl, w8_vl, w8_yl;
   logic [15:0] w8_hc, w8_mc, w8_wc;
   cache_control_nway #(.WAYS(8), .CNT_W(16)) u_w8 (
      .clk(clk), .rst(rst), .mem_read(a_read), .mem_write(1'b0), .pmem_resp(1'b0),
      .hit(a_hit8), .valid(8'b0), .dirty(8'b0), .victim(3'b0), .cnt_clr(a_clr),
      .mem_resp(w8_resp), .pmem_read(w8_pr), .pmem_write(w8_pw), .lru_load(w8_lru),
      .way_sel(w8_way), .data_load(w8_dl), .tag_load(w8_tl), .valid_load(w8_vl),
      .dirty_load(w8_yl), .dirty_in(w8_di), .data_src(w8_ds), .pmem_addr_sel(w8_as),
      .hit_cnt(w8_hc), .miss_cnt(w8_mc), .wb_cnt(w8_wc));

   logic        w2_resp, w2_pr, w2_pw, w2_lru, w2_di, w2_ds, w2_as;
   logic [0:0]  w2_way;
   logic [1:0]  w2_dl, w2_tl, w2_vl, w2_yl;
   logic [15:0] w2_hc, w2_mc, w2_wc;
   cache_control_nway #(.WAYS(2), .CNT_W(16)) u_w2 (
      .clk(clk), .rst(rst), .mem_read(a_read), .mem_write(1'b0), .pmem_resp(1'b0),
      .hit(a_hit2), .valid(2'b0), .dirty(2'b0), .victim(1'b0), .cnt_clr(a_clr),
      .mem_resp(w2_resp), .pmem_read(w2_pr), .pmem_write(w2_pw), .lru_load(w2_lru),
      .way_sel(w2_way), .data_load(w2_dl), .tag_load(w2_tl), .valid_load(w2_vl),
      .dirty_load(w2_yl), .dirty_in(w2_di), .data_src(w2_ds), .pmem_addr_sel(w2_as),
      .hit_cnt(w2_hc), .miss_cnt(w2_mc), .wb_cnt(w2_wc));

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   // Physical memory model: answers after pmem_lat active cycles
   initial forever begin
      @(posedge clk); #1;
      if (rst || !(m_pmem_read || m_pmem_write)) begin
         pmem_cnt  = 0;
         pmem_resp = 1'b0;
      end else begin
         pmem_cnt++;
         pmem_resp = (pmem_cnt == pmem_lat);
         if (pmem_resp) pmem_cnt = 0;
      end
   end

   // Monitor: every mem_resp pops one expected response
   always @(negedge clk) begin
      if (!rst && m_mem_resp) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_mem_resp", 64'(m_mem_resp), 64'(0));
         end else begin
            mon_exp = exp_q.pop_front();
            mon_got.way_sel    = m_way_sel;
            mon_got.lru_load   = m_lru_load;
            mon_got.data_load  = m_data_load;
            mon_got.tag_load   = m_tag_load;
            mon_got.valid_load = m_valid_load;
            mon_got.dirty_load = m_dirty_load;
            mon_got.dirty_in   = m_dirty_in;
            mon_got.data_src   = m_data_src;
            mon_got.pmem_rw    = {m_pmem_read, m_pmem_write};
            mon_got.addr_sel   = m_addr_sel;
            chk("resp_fields", 64'(mon_got), 64'(mon_exp));
         end
      end
   end

   task automatic wait_resp(input string name, input int want_lat);
      int  cyc = 0;
      bit  done = 0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (m_mem_resp) done = 1;
      end
      chk({name, "_latency"}, 64'(cyc), 64'(want_lat));
      @(posedge clk); #1;
      m_read  = 1'b0;
      m_write = 1'b0;
   endtask

   task automatic hit_req(input string name, input logic rd, input logic wr,
                          input logic [3:0] h, input logic [1:0] exp_way,
                          input logic [3:0] exp_dl, input logic exp_di);
      resp_t e = '0;
      e.way_sel    = exp_way;
      e.lru_load   = 1'b1;
      e.data_load  = exp_dl;
      e.dirty_load = exp_dl;
      e.dirty_in   = exp_di;
      @(posedge clk); #1;
      exp_q.push_back(e);
      m_hit = h; m_read = rd; m_write = wr;
      wait_resp(name, 2);
   endtask

   task automatic miss_req(input string name, input logic wr, input logic [1:0] vic,
                           input logic [3:0] vld, input logic [3:0] dty,
                           input logic [1:0] new_vic, input logic [3:0] exp_load,
                           input logic [1:0] exp_way, input int want_wb,
                           input int want_fill, input int want_lat);
      resp_t e = '0;
      int   cyc = 0, wb_n = 0, fill_n = 0, bad = 0;
      bit   done = 0;
      logic [4:0]  wb_v = '0;
      logic [17:0] fill_v = '0;
      e.way_sel  = exp_way;
      e.lru_load = 1'b1;
      if (wr) begin
         e.data_load  = exp_load;
         e.dirty_load = exp_load;
         e.dirty_in   = 1'b1;
      end
      @(posedge clk); #1;
      exp_q.push_back(e);
      m_victim = vic; m_valid = vld; m_dirty = dty; m_hit = 4'b0;
      m_read = ~wr; m_write = wr;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (m_pmem_write) begin
            wb_n++;
            if (!m_addr_sel || m_pmem_read || m_way_sel != exp_way) bad++;
            if (pmem_resp) wb_v = {m_dirty_load, m_dirty_in};
         end
         if (m_pmem_read) begin
            fill_n++;
            if (m_addr_sel || m_pmem_write || m_way_sel != exp_way) bad++;
            if (fill_n == 2) m_victim = new_vic;
            if (pmem_resp) begin
               fill_v = {m_data_load, m_tag_load, m_valid_load, m_dirty_load, m_data_src, m_dirty_in};
               m_hit  = exp_load;
            end
         end
         if (m_mem_resp) done = 1;
      end
      chk({name, "_latency"}, 64'(cyc), 64'(want_lat));
      chk({name, "_wb_cycles"}, 64'(wb_n), 64'(want_wb));
      chk({name, "_fill_cycles"}, 64'(fill_n), 64'(want_fill));
      chk({name, "_pmem_drive"}, 64'(bad), 64'(0));
      chk({name, "_wb_clean"}, 64'(wb_v), (want_wb > 0) ? 64'({exp_load, 1'b0}) : 64'(0));
      chk({name, "_fill_loads"}, 64'(fill_v), 64'({exp_load, exp_load, exp_load, exp_load, 2'b10}));
      @(posedge clk); #1;
      m_read = 1'b0; m_write = 1'b0; m_hit = 4'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      bit seen;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_ctrl", 64'({m_mem_resp, m_pmem_read, m_pmem_write, m_lru_load, m_way_sel,
                             m_data_load, m_tag_load, m_valid_load, m_dirty_load,
                             m_dirty_in, m_data_src, m_addr_sel}), 64'(0));
      chk("reset_cnts", 64'({m_hit_cnt, m_miss_cnt, m_wb_cnt}), 64'(0));

      hit_req("rd_hit_way2", 1'b1, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b0);
      chk("hit_cnt_after_rd", 64'(m_hit_cnt), 64'(1));
      hit_req("wr_hit_way0", 1'b0, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b1);
      hit_req("rdwr_read_prio", 1'b1, 1'b1, 4'b0010, 2'd1, 4'b0000, 1'b0);
      hit_req("lowest_hit_way", 1'b1, 1'b0, 4'b0110, 2'd1, 4'b0000, 1'b0);
      chk("hit_cnt_after_4", 64'(m_hit_cnt), 64'(4));
      chk("miss_cnt_after_hits", 64'(m_miss_cnt), 64'(0));

      @(posedge clk); #1 m_clr = 1'b1;
      @(posedge clk); #1 m_clr = 1'b0;
      chk("cnt_clr_main", 64'(m_hit_cnt), 64'(0));

      pmem_lat = 5;
      miss_req("dirty_rd_miss", 1'b0, 2'd3, 4'b1000, 4'b1000, 2'd3, 4'b1000, 2'd3, 5, 5, 14);
      chk("dm_hit_cnt", 64'(m_hit_cnt), 64'(0));
      chk("dm_miss_cnt", 64'(m_miss_cnt), 64'(1));
      chk("dm_wb_cnt", 64'(m_wb_cnt), 64'(1));

      pmem_lat = 3;
      miss_req("clean_wr_miss", 1'b1, 2'd2, 4'b0000, 4'b0100, 2'd1, 4'b0100, 2'd2, 0, 3, 7);
      chk("cm_miss_cnt", 64'(m_miss_cnt), 64'(2));
      chk("cm_wb_cnt", 64'(m_wb_cnt), 64'(1));
      chk("cm_hit_cnt", 64'(m_hit_cnt), 64'(0));

      // Reset in the middle of a fill
      pmem_lat = 50;
      @(posedge clk); #1;
      m_victim = 2'd0; m_valid = 4'b0; m_dirty = 4'b0; m_hit = 4'b0; m_read = 1'b1;
      cyc = 0;
      while (!m_pmem_read && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("rst_fill_entered", 64'(m_pmem_read), 64'(1));
      @(posedge clk); #1 rst = 1'b1; m_read = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_pmem_read", 64'(m_pmem_read), 64'(0));
      chk("rst_outputs", 64'({m_mem_resp, m_pmem_write, m_lru_load, m_way_sel, m_data_load,
                              m_tag_load, m_valid_load, m_dirty_load, m_dirty_in,
                              m_data_src, m_addr_sel}), 64'(0));
      chk("rst_cnts", 64'({m_hit_cnt, m_miss_cnt, m_wb_cnt}), 64'(0));
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (m_mem_resp || m_pmem_read) seen = 1;
      end
      chk("rst_abandoned", 64'(seen), 64'(0));
      pmem_lat = 2;

      // Associativity sweep and counter saturation
      a_hit8 = 8'b0000_0100;
      a_hit2 = 2'b10;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1 a_read = 1'b1;
         @(negedge clk);
         chk("sweep_early", 64'({c2_resp, w8_resp, w2_resp}), 64'(0));
         @(negedge clk);
         chk("sweep_resp", 64'({c2_resp, w8_resp, w2_resp, c2_lru, w8_lru, w2_lru}), 64'(6'b111111));
         chk("sweep_way8", 64'(w8_way), 64'(2));
         chk("sweep_way2", 64'(w2_way), 64'(1));
         chk("sweep_way4", 64'(c2_way), 64'(2));
         chk("sweep_no_pmem", 64'({c2_pr, c2_pw, w8_pr, w8_pw, w2_pr, w2_pw}), 64'(0));
         @(posedge clk); #1 a_read = 1'b0;
      end
      chk("sat_hit_cnt_w2bit", 64'(c2_hc), 64'(3));
      chk("hit_cnt_w8", 64'(w8_hc), 64'(5));
      chk("hit_cnt_w2", 64'(w2_hc), 64'(5));

      @(posedge clk); #1 a_read = 1'b1; a_clr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("clr_with_hit_resp", 64'(c2_resp), 64'(1));
      @(posedge clk); #1 a_read = 1'b0; a_clr = 1'b0;
      chk("clr_prio_c2", 64'(c2_hc), 64'(0));
      chk("clr_prio_w8", 64'(w8_hc), 64'(0));
      chk("clr_prio_w2", 64'(w2_hc), 64'(0));

      @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
